uart_rx_buffered: RTL

UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

---
 rtl/uart_rx_buffered.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - UART receiver with one-byte holding register and error strobes.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_buffered #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    input  logic       i_RX_Ready,
    output logic       o_RX_Valid,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_Frame_Err,
    output logic       o_Overrun,
    output logic       o_Parity_Err
);

    localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t      state, state_next;
    logic        sync_1, sync_2;
    logic [15:0] count, count_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shift, shift_next;
    logic        complete;
    logic        frame_err;
`ifdef UART_RX_PARITY_EN
    logic        par_bit, par_bit_next;
    logic        parity_err;
`endif

    assign o_RX_Active = (state != IDLE);

    always_comb begin
        state_next   = state;
        count_next   = count;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        complete     = 1'b0;
        frame_err    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_next = par_bit;
        parity_err   = 1'b0;
`endif
        case (state)
            IDLE: begin
                count_next   = 16'd0;
                bit_idx_next = 3'd0;
                if (!sync_2) begin
                    state_next = START;
                end
            end
            START: begin
                if (count == HALF_BIT) begin
                    count_next = 16'd0;
                    // A line that is high again at mid-start was only a glitch
                    state_next = sync_2 ? IDLE : DATA;
                end else begin
                    count_next = count + 16'd1;
                end
            end
            DATA: begin
                if (count == LAST_CLK) begin
                    count_next   = 16'd0;
                    shift_next   = {sync_2, shift[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    count_next = count + 16'd1;
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (count == LAST_CLK) begin
                    count_next   = 16'd0;
                    par_bit_next = sync_2;
                    state_next   = STOP;
                end else begin
                    count_next = count + 16'd1;
                end
`else
                state_next = IDLE;
`endif
            end
            STOP: begin
                if (count == LAST_CLK) begin
                    count_next = 16'd0;
                    // Leave immediately so a start bit half a bit later is still seen
                    state_next = IDLE;
                    if (!sync_2) begin
                        frame_err = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if ((^shift) != par_bit) begin
                        parity_err = 1'b1;
`endif
                    end else begin
                        complete = 1'b1;
                    end
                end else begin
                    count_next = count + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync_1      <= 1'b1;
            sync_2      <= 1'b1;
            state       <= IDLE;
            count       <= 16'd0;
            bit_idx     <= 3'd0;
            shift       <= 8'h00;
            o_RX_Valid  <= 1'b0;
            o_RX_Byte   <= 8'h00;
            o_Frame_Err <= 1'b0;
            o_Overrun   <= 1'b0;
        end else begin
            sync_1      <= i_RX_Serial;
            sync_2      <= sync_1;
            state       <= state_next;
            count       <= count_next;
            bit_idx     <= bit_idx_next;
            shift       <= shift_next;
            o_Frame_Err <= frame_err;
            o_Overrun   <= complete && o_RX_Valid && !i_RX_Ready;
            // A handshake in the completion cycle frees the register for the new byte
            if (complete && (!o_RX_Valid || i_RX_Ready)) begin
                o_RX_Byte  <= shift;
                o_RX_Valid <= 1'b1;
            end else if (o_RX_Valid && i_RX_Ready) begin
                o_RX_Valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            par_bit      <= 1'b0;
            o_Parity_Err <= 1'b0;
        end else begin
            par_bit      <= par_bit_next;
            o_Parity_Err <= parity_err;
        end
    end
`else
    assign o_Parity_Err = 1'b0;
`endif

endmodule
